// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem word request, drives the IF/ID register.
// Latency: an acked word reaches IF/ID on the edge that samples imem_ack (1 instr/cycle with a 1-cycle memory).
// Backpressure: stall freezes IF/ID and PC; a word acked under stall is parked in a hold buffer until release.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] hold_dat, hold_dat_nxt;
    if_id_t      if_id, if_id_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign pc_plus4     = pc + 32'd4;
    assign redirect_tgt = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC_ALIGNED;
            req_addr       <= 32'd0;
            hold_dat       <= 32'd0;
            if_id.instr    <= NOP_INSTR;
            if_id.pc       <= 32'd0;
            if_id.pc_plus4 <= 32'd4;
            if_id.valid    <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            hold_dat <= hold_dat_nxt;
            if_id    <= if_id_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        hold_dat_nxt = hold_dat;
        if_id_nxt    = if_id;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) begin
                    pc_nxt          = redirect_tgt;
                    hold_dat_nxt    = 32'd0;
                    if_id_nxt.instr = NOP_INSTR;
                    if_id_nxt.valid = 1'b0;
                end
            end

            FETCH: begin
                if (redirect) begin
                    pc_nxt          = redirect_tgt;
                    hold_dat_nxt    = 32'd0;
                    if_id_nxt.instr = NOP_INSTR;
                    if_id_nxt.valid = 1'b0;
                    // Unacked request is still in flight: keep presenting it and drop its data.
                    if (!imem_ack) begin
                        state_nxt    = DRAIN;
                        req_addr_nxt = pc;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_dat_nxt = imem_rdata;
                        state_nxt    = HOLD;
                    end else begin
                        if_id_nxt = '{instr: imem_rdata, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
                        pc_nxt    = pc_plus4;
                    end
                end else if (!stall) begin
                    if_id_nxt.instr = NOP_INSTR;
                    if_id_nxt.valid = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt          = redirect_tgt;
                    hold_dat_nxt    = 32'd0;
                    if_id_nxt.instr = NOP_INSTR;
                    if_id_nxt.valid = 1'b0;
                    state_nxt       = FETCH;
                end else if (!stall) begin
                    if_id_nxt = '{instr: hold_dat, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
                    pc_nxt    = pc_plus4;
                    state_nxt = FETCH;
                end
            end

            DRAIN: begin
                if_id_nxt.instr = NOP_INSTR;
                if_id_nxt.valid = 1'b0;
                if (redirect) begin
                    pc_nxt = redirect_tgt;
                end
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req       = (state == FETCH) || (state == DRAIN);
    assign imem_addr      = (state == DRAIN) ? req_addr : pc;
    assign if_id_instr    = if_id.instr;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable memory responder.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    int vec_cnt;
    int err_cnt;

    int   lat;
    logic mem_block;
    logic force_ack;
    int   wait_cnt;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: answers a request after lat cycles with addr|0x100.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        wait_cnt   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (!imem_req || mem_block) begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hBAD0_0000;
                wait_cnt   = 0;
            end else if (wait_cnt >= lat - 1) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr | 32'h0000_0100;
                wait_cnt   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hBAD0_0000;
                wait_cnt   = wait_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        lat         = 1;
        mem_block   = 1'b0;
        force_ack   = 1'b0;

        tick;
        tick;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr,          NOP);
        chk("rst_pc",    if_id_pc,             32'd0);
        chk("rst_pc4",   if_id_pc_plus4,       32'd4);
        rst_n = 1'b1;

        tick;
        chk("first_req",   {31'd0, imem_req},    32'd1);
        chk("first_addr",  imem_addr,            32'd0);
        chk("first_valid", {31'd0, if_id_valid}, 32'd0);

        // Back-to-back acks: one instruction per cycle.
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("seq_pc",    if_id_pc,             32'(4 * k));
            chk("seq_instr", if_id_instr,          32'(4 * k) | 32'h100);
            chk("seq_valid", {31'd0, if_id_valid}, 32'd1);
            chk("seq_req",   {31'd0, imem_req},    32'd1);
            chk("seq_addr",  imem_addr,            32'(4 * k + 4));
        end

        // Stall lands on the ack for 0x10.
        stall = 1'b1;
        tick;
        chk("hold_req1", {31'd0, imem_req},    32'd0);
        chk("hold_pc1",  if_id_pc,             32'h0C);
        chk("hold_vld1", {31'd0, if_id_valid}, 32'd1);
        tick;
        chk("hold_req2", {31'd0, imem_req}, 32'd0);
        chk("hold_pc2",  if_id_pc,          32'h0C);
        tick;
        chk("hold_req3", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick;
        chk("rel_pc",    if_id_pc,             32'h10);
        chk("rel_instr", if_id_instr,          32'h110);
        chk("rel_valid", {31'd0, if_id_valid}, 32'd1);
        chk("rel_addr",  imem_addr,            32'h14);

        // Two-cycle memory: bubble between instructions.
        lat = 2;
        tick;
        chk("lat2_bub_valid", {31'd0, if_id_valid}, 32'd0);
        chk("lat2_bub_instr", if_id_instr,          NOP);
        chk("lat2_bub_pc",    if_id_pc,             32'h10);
        chk("lat2_addr_a",    imem_addr,            32'h14);
        tick;
        chk("lat2_pc_a",    if_id_pc,    32'h14);
        chk("lat2_instr_a", if_id_instr, 32'h114);
        chk("lat2_addr_b",  imem_addr,   32'h18);
        tick;
        chk("lat2_bub2",     {31'd0, if_id_valid}, 32'd0);
        chk("lat2_stable_b", imem_addr,            32'h18);
        tick;
        chk("lat2_pc_b", if_id_pc, 32'h18);
        tick;
        chk("lat2_addr_c", imem_addr, 32'h1C);
        tick;
        chk("lat2_pc_c", if_id_pc,  32'h1C);
        chk("pre_rd_addr", imem_addr, 32'h20);

        // Redirect while the request to 0x20 is outstanding.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        mem_block   = 1'b1;
        tick;
        redirect = 1'b0;
        chk("drain_req",   {31'd0, imem_req},    32'd1);
        chk("drain_addr",  imem_addr,            32'h20);
        chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
        chk("drain_instr", if_id_instr,          NOP);
        tick;
        chk("drain_addr2",  imem_addr,            32'h20);
        chk("drain_valid2", {31'd0, if_id_valid}, 32'd0);
        mem_block = 1'b0;
        lat       = 1;
        tick;
        chk("drain_done_addr",  imem_addr,            32'h200);
        chk("drain_done_valid", {31'd0, if_id_valid}, 32'd0);
        chk("drain_done_instr", if_id_instr,          NOP);
        tick;
        chk("tgt_pc",    if_id_pc,             32'h200);
        chk("tgt_instr", if_id_instr,          32'h300);
        chk("tgt_valid", {31'd0, if_id_valid}, 32'd1);

        // Redirect and stall together: flush wins.
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0400;
        tick;
        redirect = 1'b0;
        stall    = 1'b0;
        chk("rs_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rs_instr", if_id_instr,          NOP);
        chk("rs_pc",    if_id_pc,             32'h200);
        chk("rs_addr",  imem_addr,            32'h400);
        tick;
        chk("rs_new_pc",    if_id_pc,       32'h400);
        chk("rs_new_instr", if_id_instr,    32'h500);
        chk("rs_new_pc4",   if_id_pc_plus4, 32'h404);

        // Wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick;
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick;
        chk("wrap_pc",    if_id_pc,             32'hFFFF_FFFC);
        chk("wrap_pc4",   if_id_pc_plus4,       32'h0);
        chk("wrap_valid", {31'd0, if_id_valid}, 32'd1);
        chk("wrap_next",  imem_addr,            32'h0);

        // Reset asserted mid-request.
        mem_block = 1'b1;
        tick;
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imem_req},    32'd0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_instr", if_id_instr,          NOP);
        chk("arst_pc",    if_id_pc,             32'd0);
        chk("arst_pc4",   if_id_pc_plus4,       32'd4);
        mem_block = 1'b0;
        tick;
        chk("arst_hold_req", {31'd0, imem_req}, 32'd0);
        rst_n     = 1'b1;
        force_ack = 1'b1;
        tick;
        force_ack = 1'b0;
        chk("idle_ack_req",   {31'd0, imem_req},    32'd1);
        chk("idle_ack_addr",  imem_addr,            32'd0);
        chk("idle_ack_valid", {31'd0, if_id_valid}, 32'd0);
        tick;
        chk("restart_pc",    if_id_pc,    32'd0);
        chk("restart_instr", if_id_instr, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Owns the program counter and issues single-outstanding word requests to instruction memory.
- Holds the IF/ID pipeline register (instruction, PC, PC+4, valid) that drives the decoder.
- Supports stall from the hazard unit and redirect/flush from branch/jump resolution; inserts NOP bubbles when no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) presented when if_id_valid=0.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the IF/ID register; do not advance the PC.
- redirect  input  1  taken branch/jump: flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored, forced to 00.
- imem_req  output  1  instruction memory request valid.
- imem_addr  output  32  word-aligned fetch address.
- imem_ack  input  1  memory response; imem_rdata valid in this cycle.
- imem_rdata  input  32  fetched instruction word.
- if_id_instr  output  32  instruction to the decoder.
- if_id_pc  output  32  PC of if_id_instr.
- if_id_pc_plus4  output  32  if_id_pc+4, used as the link value.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While rst_n=0:
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=4.
  - Hold buffer cleared.
  - Reset asserted mid-request abandons the request immediately; any later ack is ignored in IDLE.
- States: IDLE, FETCH, HOLD, DRAIN.
  - IDLE: the first edge after reset release moves to FETCH.
- Memory protocol:
  - imem_req=1 in FETCH and DRAIN only.
  - imem_addr is stable while imem_req=1 until imem_ack is sampled high.
  - imem_ack is ignored when imem_req=0.
  - Memory with ack in every cycle yields one instruction per cycle: the address advances on the edge that samples the ack.
- FETCH:
  - ack & !stall: IF/ID <= {imem_rdata, pc, pc+4, valid=1}; pc <= pc+4; stay FETCH.
  - ack & stall: capture rdata into the hold buffer; IF/ID unchanged; go HOLD with imem_req=0.
  - !ack & !stall: IF/ID <= bubble (valid=0, instr=NOP_INSTR; pc fields unchanged).
  - !ack & stall: IF/ID unchanged.
- HOLD:
  - While stall=1: no request; nothing changes.
  - When stall=0: IF/ID <= hold buffer with its pc; pc <= pc+4; go FETCH.
- Redirect (highest priority, overrides stall):
  - IF/ID <= bubble; hold buffer discarded; pc <= {redirect_pc[31:2],2'b00}.
  - From FETCH with no ack in the same cycle: the request is outstanding, so go DRAIN. imem_req stays high with the old address until ack; the ack data is discarded; then go FETCH at the new pc.
  - From FETCH with ack in the same cycle: discard data; go FETCH at the new pc on the next cycle.
  - From HOLD or IDLE: go FETCH at the new pc.
  - In DRAIN: replaces the pending target; remain in DRAIN.
- DRAIN: IF/ID is held as a bubble regardless of stall.
- Arithmetic: pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000. The same rule applies to if_id_pc_plus4.
- Invariant: an instruction reaches IF/ID at most once, never out of order, and never after a redirect that postdates its request.

Test Plan:
- Reset release with RESET_PC=0 and memory acking every cycle with rdata=pc|0x100 → if_id_pc sequence 0,4,8,C…; if_id_valid=1 from cycle 2; imem_req continuously high.
- Memory with 2-cycle ack latency → a bubble (valid=0, instr=0x00000013) between instructions; imem_addr stable while waiting.
- stall=1 for 3 cycles coinciding with an ack at pc=0x10:
  - IF/ID holds 0xC; imem_req=0 in HOLD.
  - After release, IF/ID=0x10 contents with no re-fetch.
  - Next request is 0x14.
- redirect=1 with redirect_pc=0x203 while a request to 0x20 is outstanding → DRAIN until ack; the 0x20 data never appears; next request is 0x200; IF/ID is a bubble meanwhile.
- redirect and stall asserted together in the same cycle → flush wins: IF/ID becomes a bubble; fetch restarts at the target.
- pc=0xFFFF_FFFC acked → if_id_pc_plus4=0; next imem_addr=0; rst_n pulsed low mid-request → outputs return to reset values asynchronously.
